// File: rtl/counter_sequencer_pkg.sv
// Shared state encoding, default sizes and state decode helpers for the
// counter sequencer.
package counter_sequencer_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_REP_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } seq_state_t;

   // The sequencer owns the counter only while loading or running a period.
   function automatic logic state_busy(input seq_state_t s);
      return (s == S_LOAD) || (s == S_RUN);
   endfunction

endpackage

// File: rtl/counter_sequencer.sv
// Sequencer for the universal counter: loads the preset, lets the counter run
// to carry-out, and repeats for a programmed number of periods with hold/abort.
module counter_sequencer
   import counter_sequencer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int REP_W = DEF_REP_W
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   input  logic             stop,
   input  logic             hold,
   input  logic [WIDTH-1:0] preset,
   input  logic [REP_W-1:0] reps,
   output logic             busy,
   output logic             tick,
   output logic             done,
   output logic [REP_W-1:0] rep_cnt,
   output logic             ctr_load,
   output logic             ctr_count,
   output logic [WIDTH-1:0] ctr_din,
   input  logic             ctr_cout
);

   seq_state_t       state_reg, state_next;
   logic [WIDTH-1:0] preset_reg, preset_next;
   logic [REP_W-1:0] reps_reg, reps_next;
   logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
   logic             tick_reg, tick_next;
   logic [REP_W:0]   rep_inc;
   logic             last_period;

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         preset_reg  <= '0;
         reps_reg    <= '0;
         rep_cnt_reg <= '0;
         tick_reg    <= 1'b0;
      end else begin
         preset_reg  <= preset_next;
         reps_reg    <= reps_next;
         rep_cnt_reg <= rep_cnt_next;
         tick_reg    <= tick_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      preset_next  = preset_reg;
      reps_next    = reps_reg;
      rep_cnt_next = rep_cnt_reg;
      tick_next    = 1'b0;
      // One extra bit so the final-period compare still works at reps = all-ones.
      rep_inc      = {1'b0, rep_cnt_reg} + 1'b1;
      last_period  = (reps_reg != '0) && (rep_inc == {1'b0, reps_reg});

      if (stop) begin
         state_next = S_IDLE;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  state_next   = S_LOAD;
                  preset_next  = preset;
                  reps_next    = reps;
                  rep_cnt_next = '0;
               end
            end
            S_LOAD: begin
               state_next = S_RUN;
            end
            S_RUN: begin
               if (ctr_cout) begin
                  tick_next    = 1'b1;
                  // Continuous mode pins the count at all-ones instead of wrapping.
                  rep_cnt_next = rep_inc[REP_W] ? rep_cnt_reg : rep_inc[REP_W-1:0];
                  state_next   = last_period ? S_DONE : S_LOAD;
               end
            end
            S_DONE: begin
               state_next = S_IDLE;
            end
            default: begin
               state_next = S_IDLE;
            end
         endcase
      end
   end

   assign busy      = state_busy(state_reg);
   assign done      = (state_reg == S_DONE);
   assign tick      = tick_reg;
   assign rep_cnt   = rep_cnt_reg;
   assign ctr_load  = (state_reg == S_LOAD);
   assign ctr_count = (state_reg == S_RUN) && !hold;
   assign ctr_din   = preset_reg;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer with a behavioural 4-bit counter beside it;
// tick times are predicted arithmetically from preset, reps, hold and stop timing.
module tb_counter_sequencer;

   logic       clk;
   logic       clear;
   logic       start;
   logic       stop;
   logic       hold;
   logic [3:0] preset;
   logic [7:0] reps;
   logic       busy;
   logic       tick;
   logic       done;
   logic [7:0] rep_cnt;
   logic       ctr_load;
   logic       ctr_count;
   logic [3:0] ctr_din;
   logic       ctr_cout;
   logic [3:0] a_count;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int cyc;
      int rep;
      bit done;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   counter_sequencer #(.WIDTH(4), .REP_W(8)) dut (
      .clk       (clk),
      .clear     (clear),
      .start     (start),
      .stop      (stop),
      .hold      (hold),
      .preset    (preset),
      .reps      (reps),
      .busy      (busy),
      .tick      (tick),
      .done      (done),
      .rep_cnt   (rep_cnt),
      .ctr_load  (ctr_load),
      .ctr_count (ctr_count),
      .ctr_din   (ctr_din),
      .ctr_cout  (ctr_cout)
   );

   // Behavioural universal counter: load beats count, carry while at all-ones and counting.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) a_count <= '0;
      else if (ctr_load) a_count <= ctr_din;
      else if (ctr_count) a_count <= a_count + 4'd1;
   end
   assign ctr_cout = ctr_count && (a_count == 4'hF);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every tick/done the DUT presents must match the head of the queue.
   always @(negedge clk) begin
      if (tick || done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: tick=%0b done=%0b at cycle %0d, required none",
                     tick, done, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("tick_cycle", cyc, mon_e.cyc);
            chk("tick_flag", int'(tick), 1);
            chk("tick_rep_cnt", int'(rep_cnt), mon_e.rep);
            chk("tick_done", int'(done), int'(mon_e.done));
            $display("tick cycle=%0d rep_cnt=%0d done=%0b", cyc, rep_cnt, done);
         end
      end
   end

   // One accepted start: p/r programme, optional stop offset, one hold window in the
   // first period (h0..h0+hl-1 cycles after accept) and an optional ignored re-start.
   task automatic run_seq(input int p, input int r, input int stop_off,
                          input int h0, input int hl, input int rs_off);
      int a, per, nt, t, t_last, s_edge, end_c, busy_end, off, rep_exp;
      per    = 17 - p;
      a      = cyc + 1;
      s_edge = (stop_off >= 0) ? a + stop_off + 1 : 1000000000;
      nt     = 0;
      t_last = a;
      for (int k = 1; k <= 300; k++) begin
         t = a + k * per + hl;
         if ((r != 0 && k > r) || t >= s_edge) break;
         exp_q.push_back('{t, (k > 255) ? 255 : k, (k == r)});
         nt     = k;
         t_last = t;
      end
      busy_end = s_edge;
      if (r != 0 && nt == r && t_last < busy_end) busy_end = t_last;
      end_c = (stop_off >= 0) ? s_edge : t_last + 1;

      preset = 4'(p);
      reps   = 8'(r);
      start  = 1'b1;
      @(negedge clk);
      while (cyc < end_c) begin
         off = cyc - a;
         if (off == 0) begin
            chk("ctr_load_on_accept", int'(ctr_load), 1);
            chk("rep_cnt_cleared", int'(rep_cnt), 0);
         end
         chk("busy", int'(busy), int'(cyc < busy_end));
         chk("ctr_din_latched", int'(ctr_din), p);
         if (hl > 0 && off > h0 && off <= h0 + hl)
            chk("count_frozen", int'(a_count), p + h0 - 1);
         start  = (rs_off > 0 && off == rs_off);
         preset = start ? 4'd3 : 4'($urandom_range(0, 15));
         hold   = (hl > 0 && off >= h0 && off < h0 + hl);
         stop   = (stop_off >= 0 && off == stop_off);
         @(negedge clk);
      end
      start = 1'b0;
      stop  = 1'b0;
      hold  = 1'b0;
      rep_exp = (nt > 255) ? 255 : nt;
      chk("end_busy", int'(busy), 0);
      chk("end_ctr_count", int'(ctr_count), 0);
      chk("end_rep_cnt", int'(rep_cnt), rep_exp);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("run preset=%0d reps=%0d stop_off=%0d hold=%0d@%0d restart=%0d ticks=%0d",
               p, r, stop_off, hl, h0, rs_off, nt);
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation still running at cycle %0d, required finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int p, per, r, mode, h0, hl, so, rs;
      clear  = 1'b0;
      start  = 1'b0;
      stop   = 1'b0;
      hold   = 1'b0;
      preset = 4'd0;
      reps   = 8'd0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_tick", int'(tick), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_rep_cnt", int'(rep_cnt), 0);
      chk("rst_ctr_load", int'(ctr_load), 0);
      chk("rst_ctr_count", int'(ctr_count), 0);
      chk("rst_ctr_din", int'(ctr_din), 0);
      clear = 1'b1;
      @(negedge clk);

      run_seq(12, 2, -1, 0, 0, 0);   // ticks 5 apart, done with the second
      run_seq(12, 2, -1, 0, 0, 3);   // start re-pulsed with preset 3 while busy
      run_seq(0, 0, 51, 0, 0, 0);    // continuous, stop right after the third tick
      run_seq(10, 1, -1, 3, 4, 0);   // 4 hold cycles stretch the period to 11
      run_seq(15, 3, -1, 0, 0, 0);   // 2-cycle periods

      // start and stop together in IDLE: nothing is accepted
      preset = 4'd4;
      reps   = 8'd1;
      start  = 1'b1;
      stop   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      chk("startstop_busy", int'(busy), 0);
      chk("startstop_load", int'(ctr_load), 0);
      chk("startstop_din", int'(ctr_din), 15);
      @(negedge clk);
      chk("startstop_busy2", int'(busy), 0);

      run_seq(15, 0, 520, 0, 0, 0);  // continuous long enough for rep_cnt to saturate

      // clear mid-RUN: outputs drop without waiting for a clock edge
      preset = 4'd5;
      reps   = 8'd0;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      chk("preclear_count", int'(ctr_count), 1);
      #2 clear = 1'b0;
      #1;
      chk("clear_busy", int'(busy), 0);
      chk("clear_ctr_load", int'(ctr_load), 0);
      chk("clear_ctr_count", int'(ctr_count), 0);
      chk("clear_ctr_din", int'(ctr_din), 0);
      chk("clear_rep_cnt", int'(rep_cnt), 0);
      chk("clear_tick", int'(tick), 0);
      chk("clear_done", int'(done), 0);
      @(negedge clk);
      clear = 1'b1;
      repeat (20) @(negedge clk);
      chk("postclear_busy", int'(busy), 0);
      $display("clear mid-run released at cycle %0d", cyc);

      for (int n = 0; n < 40; n++) begin
         p    = $urandom_range(0, 15);
         per  = 17 - p;
         mode = $urandom_range(0, 2);
         h0   = $urandom_range(1, per - 1);
         hl   = $urandom_range(0, 5);
         r    = (mode == 2) ? 0 : $urandom_range(1, 4);
         so   = -1;
         rs   = 0;
         if (mode == 0) rs = $urandom_range(1, r * per + hl);
         if (mode == 1) so = $urandom_range(0, r * per + hl + 1);
         if (mode == 2) so = $urandom_range(0, 3 * per + hl);
         run_seq(p, r, so, h0, hl, rs);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
